// File: rtl/tdc_multihit_core.sv
// -----------------------------------------------------------------------------
// tdc_multihit_core
//
// Multi-hit time-to-digital converter core. A rising edge on start_i opens a
// measurement frame of WINDOW clk_i cycles. Each rising edge of trigger_i
// inside the frame is timestamped as {coarse, fine}:
//   - coarse: a free-running cycle counter that starts at 0 on the start edge;
//   - fine  : the position of the 0->1 transition in the DLL phase taps.
// An intensity value, the popcount of the SPAD enable lanes when tgate_i is
// high, is stored with each hit. Up to DEPTH hits are buffered. When the
// window ends, or the buffer fills, the frame is streamed out one hit per
// beat, and irq_o pulses once after the last beat.
//
// Ports
//   clk_i        in   clock
//   rst_n        in   asynchronous active-low reset
//   phase_i      in   NPHASE DLL phase taps, sampled on clk_i
//   start_i      in   frame start request (rising edge acts)
//   trigger_i    in   SPAD hit (rising edge acts)
//   spaden_i     in   SPAD_N per-SPAD fired flags
//   tgate_i      in   intensity gate
//   m_data_o     out  timestamp {coarse, fine}
//   m_int_o      out  intensity of the current beat
//   m_num_o      out  number of hits in the frame (constant over the beats)
//   m_last_o     out  final beat of the frame
//   m_valid_o    out  beat valid
//   m_ready_i    in   downstream ready
//   irq_o        out  one-cycle frame-done pulse
//   ovf_o        out  sticky: a hit was lost because the buffer was full
//   perr_o       out  sticky: a hit saw a phase pattern with no 0->1 transition
//   state_o      out  FSM state (0 IDLE, 1 MEAS, 2 OUT) for observation
//
// Stream handshake: a beat is presented with m_valid_o = 1 and completes on a
// clk_i edge where m_valid_o & m_ready_i. While m_ready_i = 0 the payload,
// m_last_o and m_valid_o hold unchanged. m_valid_o does not depend on
// m_ready_i.
// -----------------------------------------------------------------------------
module tdc_multihit_core #(
   parameter int NPHASE = 32,
   parameter int CNT_W  = 10,
   parameter int SPAD_N = 16,
   parameter int DEPTH  = 4,
   parameter int WINDOW = 1000,
   localparam int FW    = $clog2(NPHASE),
   localparam int IW    = $clog2(SPAD_N + 1),
   localparam int NW    = $clog2(DEPTH + 1)
) (
   input  logic                clk_i,
   input  logic                rst_n,
   input  logic [NPHASE-1:0]   phase_i,
   input  logic                start_i,
   input  logic                trigger_i,
   input  logic [SPAD_N-1:0]   spaden_i,
   input  logic                tgate_i,
   output logic [CNT_W+FW-1:0] m_data_o,
   output logic [IW-1:0]       m_int_o,
   output logic [NW-1:0]       m_num_o,
   output logic                m_last_o,
   output logic                m_valid_o,
   input  logic                m_ready_i,
   output logic                irq_o,
   output logic                ovf_o,
   output logic                perr_o,
   output logic [1:0]          state_o
);

   // Buffer index width; the hit count itself needs one extra value (DEPTH).
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MEAS = 2'd1,
      S_OUT  = 2'd2
   } state_t;

   state_t            state_q, state_d;

   logic              start_q, trig_q;
   logic              start_edge, trig_edge;

   logic [CNT_W-1:0]  cnt_q;
   logic [NW-1:0]     count_q;
   logic [NW-1:0]     rd_q;
   logic              ovf_q, perr_q, irq_q;

   logic [CNT_W-1:0]  buf_coarse [DEPTH];
   logic [FW-1:0]     buf_fine   [DEPTH];
   logic [IW-1:0]     buf_int    [DEPTH];

   logic [NPHASE-1:0] rise;
   logic [FW-1:0]     fine_code;
   logic              fine_err;
   logic [IW-1:0]     hit_int;

   logic              hit_store;
   logic              buf_full_next;
   logic              window_end;
   logic              beat_done;
   logic              last_beat;

   // ---------------------------------------------------------------------------
   // Edge detection and per-hit measurement
   // ---------------------------------------------------------------------------
   assign start_edge = start_i & ~start_q;
   assign trig_edge  = trigger_i & ~trig_q;

   // rise[i] = phase[i] & ~phase[i-1 mod NPHASE]; the lowest set bit wins.
   always_comb begin
      rise      = phase_i & ~{phase_i[NPHASE-2:0], phase_i[NPHASE-1]};
      fine_code = '0;
      for (int i = NPHASE - 1; i >= 0; i--) begin
         if (rise[i]) fine_code = FW'(i);
      end
   end

   // All-ones or all-zeros taps have no transition: no valid fine code.
   assign fine_err = ~|rise;
   assign hit_int  = tgate_i ? IW'($countones(spaden_i)) : '0;

   assign hit_store     = (state_q == S_MEAS) && trig_edge && (count_q < NW'(DEPTH));
   assign buf_full_next = hit_store && (count_q == NW'(DEPTH - 1));
   assign window_end    = (state_q == S_MEAS) && (cnt_q == CNT_W'(WINDOW - 1));
   assign beat_done     = (state_q == S_OUT) && m_ready_i;
   assign last_beat     = (rd_q == (count_q - NW'(1)));

   // ---------------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // ---------------------------------------------------------------------------
   // FSM: next state
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (start_edge) state_d = S_MEAS;
         end
         S_MEAS: begin
            // A hit on the closing edge still counts toward "frame has hits".
            if (buf_full_next || window_end) begin
               if ((count_q == '0) && !hit_store) state_d = S_IDLE;
               else                               state_d = S_OUT;
            end
         end
         S_OUT: begin
            if (beat_done && last_beat) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // FSM: outputs
   // ---------------------------------------------------------------------------
   always_comb begin
      m_valid_o = 1'b0;
      m_last_o  = 1'b0;
      m_data_o  = '0;
      m_int_o   = '0;
      m_num_o   = '0;
      if (state_q == S_OUT) begin
         m_valid_o = 1'b1;
         m_last_o  = last_beat;
         m_data_o  = {buf_coarse[rd_q[AW-1:0]], buf_fine[rd_q[AW-1:0]]};
         m_int_o   = buf_int[rd_q[AW-1:0]];
         m_num_o   = count_q;
      end
   end

   assign irq_o   = irq_q;
   assign ovf_o   = ovf_q;
   assign perr_o  = perr_q;
   assign state_o = state_q;

   // ---------------------------------------------------------------------------
   // Control datapath: counters, sticky flags, frame-done pulse
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         start_q <= 1'b0;
         trig_q  <= 1'b0;
         cnt_q   <= '0;
         count_q <= '0;
         rd_q    <= '0;
         ovf_q   <= 1'b0;
         perr_q  <= 1'b0;
         irq_q   <= 1'b0;
      end else begin
         start_q <= start_i;
         trig_q  <= trigger_i;
         irq_q   <= beat_done && last_beat;

         case (state_q)
            S_IDLE: begin
               if (start_edge) begin
                  cnt_q   <= '0;
                  count_q <= '0;
                  rd_q    <= '0;
                  ovf_q   <= 1'b0;
                  perr_q  <= 1'b0;
               end
            end
            S_MEAS: begin
               if (cnt_q != {CNT_W{1'b1}}) cnt_q <= cnt_q + 1'b1;
               if (hit_store) begin
                  count_q <= count_q + 1'b1;
                  if (fine_err) perr_q <= 1'b1;
               end
            end
            S_OUT: begin
               if (beat_done) rd_q <= rd_q + 1'b1;
            end
            default: ;
         endcase

         // The frame closes as soon as the buffer fills, so a further hit can
         // only show up while the full frame is draining. It is not stored but
         // is recorded as lost.
         if ((state_q != S_IDLE) && trig_edge && (count_q == NW'(DEPTH)))
            ovf_q <= 1'b1;
      end
   end

   // ---------------------------------------------------------------------------
   // Hit buffer. Entries are only read below count_q, so no reset is needed.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (hit_store) begin
         buf_coarse[count_q[AW-1:0]] <= cnt_q;
         buf_fine[count_q[AW-1:0]]   <= fine_code;
         buf_int[count_q[AW-1:0]]    <= hit_int;
      end
   end

endmodule

// File: doc/tdc_multihit_core.md
TDC_MULTIHIT_CORE -- requirements
Module: tdc_multihit_core

Interface
REQ-001 Parameter NPHASE, default 32, number of DLL phase taps (power of 2, min 4); FW = log2(NPHASE).
REQ-002 Parameter CNT_W, default 10, coarse counter width.
REQ-003 Parameter SPAD_N, default 16, SPAD enable lanes; IW = clog2(SPAD_N+1).
REQ-004 Parameter DEPTH, default 4, max hits per frame; NW = clog2(DEPTH+1).
REQ-005 Parameter WINDOW, default 1000, measurement window length in clk_i cycles (< 2^CNT_W).
REQ-006 clk_i  input  1  logic/sample clock.
REQ-007 rst_n  input  1  asynchronous, active-low reset.
REQ-008 phase_i  input  NPHASE  DLL phase taps, sampled on clk_i.
REQ-009 start_i  input  1  frame start request, level, rising edge acts.
REQ-010 trigger_i  input  1  SPAD hit, rising edge acts.
REQ-011 spaden_i  input  SPAD_N  per-SPAD fired flags.
REQ-012 tgate_i  input  1  intensity gate.
REQ-013 m_data_o  output  CNT_W+FW  timestamp {coarse, fine}.
REQ-014 m_int_o  output  IW  intensity of the beat.
REQ-015 m_num_o  output  NW  hit count of the frame, constant across all beats.
REQ-016 m_last_o / m_valid_o  output  1 each  stream last and valid.
REQ-017 m_ready_i  input  1  stream ready.
REQ-018 irq_o  output  1  frame-done pulse; ovf_o output 1 sticky overflow; perr_o output 1 sticky phase error.

Function
REQ-019 FSM states: IDLE, MEAS, OUT; reset state IDLE.
REQ-020 IDLE -> MEAS on the clk_i edge where start_i = 1 and its previous sample = 0; the coarse counter loads 0 and the hit buffer, count, ovf_o and perr_o clear on that edge.
REQ-021 In MEAS the coarse counter increments by 1 each edge; start_i edges are ignored.
REQ-022 A hit is accepted on an edge where trigger_i = 1 and its previous sample = 0: coarse = counter value on that edge; fine = phase_i value on that edge.
REQ-023 The fine code is the lowest index i with phase_i[i] = 1 and phase_i[(i-1) mod NPHASE] = 0; if no such i exists, fine = 0 and perr_o sets.
REQ-024 Intensity = popcount(spaden_i) if tgate_i = 1 on the hit edge, else 0.
REQ-025 Hits are stored in arrival order; hits beyond DEPTH are dropped and set ovf_o.
REQ-026 MEAS -> OUT when the counter equals WINDOW-1, or on the edge that stores hit number DEPTH; a hit on the transition edge is still stored if there is space.
REQ-027 If the frame holds 0 hits at window end: MEAS -> IDLE, no beats, no irq_o.
REQ-028 In OUT, beat k (0-based) presents hit k with m_valid_o = 1; a beat completes on an edge with m_valid_o & m_ready_i.
REQ-029 Payload and m_valid_o are held stable while m_ready_i = 0.
REQ-030 m_last_o = 1 only on the final beat; after it completes: irq_o = 1 for exactly one cycle and OUT -> IDLE.
REQ-031 Triggers during OUT and IDLE are ignored; a start edge in IDLE the cycle after OUT is accepted normally.
REQ-032 The coarse counter saturates at 2^CNT_W-1 (no wrap).

Reset
REQ-033 Asserting rst_n low at any time forces IDLE, counter 0, buffer count 0, m_valid_o, m_last_o, irq_o, ovf_o and perr_o 0, m_data_o, m_int_o and m_num_o 0; an in-flight frame is discarded.
REQ-034 The previous samples of start_i and trigger_i reset to 0.

Verification
REQ-035 Start edge, trigger rising 100 cycles later, phase_i = 0xFFFF0000, spaden_i = 0x0001, tgate_i = 1, m_ready_i = 1 -> one beat with m_data_o = {10'd100, 5'd16}, m_int_o = 1, m_num_o = 1, m_last_o = 1, and an irq_o pulse.
REQ-036 Five hits with spaden_i = 0x0001, 0x00F1, 0x0FF1, 0x3FF1, 0x30F1 in one frame -> 4 beats with m_int_o = 1, 5, 9, 11; m_num_o = 4; ovf_o = 1; the fifth hit is not output.
REQ-037 Two hits, m_ready_i = 0 for 10 cycles, then 1 -> beat 0 is held unchanged while m_ready_i = 0; m_last_o = 1 only on beat 1; exactly one irq_o pulse.
REQ-038 Start edge with no trigger -> return to IDLE after WINDOW cycles; m_valid_o and irq_o never assert.
REQ-039 phase_i = all ones on the hit edge -> fine = 0 and perr_o = 1; perr_o clears on the next start edge.
REQ-040 rst_n pulsed low mid-OUT with m_ready_i = 0 -> all outputs 0 immediately; the next start edge gives a clean frame with m_num_o counting only the new hits.
